store_buffer_ctrl: RTL and testbench

STORE_BUFFER_CTRL -- requirements
Module: store_buffer_ctrl

---
 rtl/store_buffer_ctrl_if.sv | 49 ++++
 rtl/store_buffer_ctrl.sv | 111 +++++++++++
 tb/tb_store_buffer_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_ctrl_if.sv
// rtl/store_buffer_ctrl_if.sv - store buffer request, load-check, fence and memory signal bundle
interface store_buffer_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            i_enq_valid;
  logic [XLEN-1:0] i_enq_addr;
  logic [XLEN-1:0] i_enq_data;
  logic [3:0]      i_enq_be;
  logic            o_enq_ready;

  logic            i_ld_check_valid;
  logic [XLEN-1:0] i_ld_check_addr;
  logic            o_ld_hazard;

  logic            i_fence_req;
  logic            o_fence_done;

  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [3:0]      o_mem_be;

  logic [CW-1:0]   o_count;
  logic            o_empty;

  // Store unit / load pipe / data memory side
  modport master (
    output i_enq_valid, i_enq_addr, i_enq_data, i_enq_be,
    output i_ld_check_valid, i_ld_check_addr,
    output i_fence_req, i_mem_ready,
    input  o_enq_ready, o_ld_hazard, o_fence_done,
    input  o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be,
    input  o_count, o_empty
  );

  // Store buffer side
  modport slave (
    input  i_enq_valid, i_enq_addr, i_enq_data, i_enq_be,
    input  i_ld_check_valid, i_ld_check_addr,
    input  i_fence_req, i_mem_ready,
    output o_enq_ready, o_ld_hazard, o_fence_done,
    output o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_be,
    output o_count, o_empty
  );
endinterface

// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - in-order store buffer with load hazard detection and fence drain
module store_buffer_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  store_buffer_ctrl_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } fence_state_t;

  fence_state_t state_q, state_d;

  // Only the word address is kept: memory sees the low two bits as zero
  // and the hazard check compares words.
  logic [XLEN-3:0] word_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [3:0]      be_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic enq_ready;
  logic enq_write;
  logic deq_fire;
  logic hit;
  logic unused_low_bits;

  assign unused_low_bits = ^{sb.i_enq_addr[1:0], sb.i_ld_check_addr[1:0]};

  // A zero byte-enable request is handshaken but never stored.
  assign enq_ready = (count_q < CW'(DEPTH)) && (state_q == IDLE);
  assign enq_write = sb.i_enq_valid && enq_ready && (sb.i_enq_be != 4'b0000);
  assign deq_fire  = (count_q != '0) && sb.i_mem_ready;

  assign sb.o_enq_ready  = enq_ready;
  assign sb.o_mem_valid  = (count_q != '0);
  assign sb.o_mem_addr   = {word_q[head_q], 2'b00};
  assign sb.o_mem_wdata  = data_q[head_q];
  assign sb.o_mem_be     = be_q[head_q];
  assign sb.o_count      = count_q;
  assign sb.o_empty      = (count_q == '0);
  assign sb.o_fence_done = (state_q == DONE);

  // Entry payload is written at the tail; it needs no reset because valid_q gates every use.
  always_ff @(posedge i_clk) begin
    if (enq_write) begin
      word_q[tail_q] <= sb.i_enq_addr[XLEN-1:2];
      data_q[tail_q] <= sb.i_enq_data;
      be_q[tail_q]   <= sb.i_enq_be;
    end
  end

  // Pointers, occupancy and per-entry valid bits; enqueue and dequeue never hit the same slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq_write) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
      if (deq_fire) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
      case ({enq_write, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A load stalls on any pending store to its word, including one leaving or arriving this cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (word_q[i] == sb.i_ld_check_addr[XLEN-1:2])) hit = 1'b1;
    end
    if (enq_write && (sb.i_enq_addr[XLEN-1:2] == sb.i_ld_check_addr[XLEN-1:2])) hit = 1'b1;
    sb.o_ld_hazard = sb.i_ld_check_valid && hit;
  end

  // Fence state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Fence sequencing: block new stores, wait for the buffer to empty, pulse done once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sb.i_fence_req) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb/tb_store_buffer_ctrl.sv - scoreboard bench for store_buffer_ctrl with reference model
module tb_store_buffer_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH)) sbif ();
  store_buffer_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sb   (sbif)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  st_t model_q[$];
  st_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  draining = 1'b0;
  bit  done_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the buffer is a queue of pending stores; the fence is "draining" then one done cycle.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      sb_q.delete();
      draining  = 1'b0;
      done_pend = 1'b0;
    end else begin : model_cycle
      int n;
      bit exp_ready, acc, haz;
      st_t e;
      n         = model_q.size();
      exp_ready = (n < DEPTH) && !draining && !done_pend;
      acc       = sbif.i_enq_valid && exp_ready;
      haz       = 1'b0;
      if (sbif.i_ld_check_valid) begin
        foreach (model_q[k])
          if (model_q[k].addr[31:2] == sbif.i_ld_check_addr[31:2]) haz = 1'b1;
        if (acc && sbif.i_enq_be != 4'h0 && sbif.i_enq_addr[31:2] == sbif.i_ld_check_addr[31:2])
          haz = 1'b1;
      end
      chk("enq_ready",  sbif.o_enq_ready,  exp_ready);
      chk("count",      sbif.o_count,      n);
      chk("empty",      sbif.o_empty,      n == 0);
      chk("mem_valid",  sbif.o_mem_valid,  n != 0);
      chk("ld_hazard",  sbif.o_ld_hazard,  haz);
      chk("fence_done", sbif.o_fence_done, done_pend);
      if (n != 0 && sbif.i_mem_ready) void'(model_q.pop_front());
      if (acc && sbif.i_enq_be != 4'h0) begin
        e.addr = {sbif.i_enq_addr[31:2], 2'b00};
        e.data = sbif.i_enq_data;
        e.be   = sbif.i_enq_be;
        model_q.push_back(e);
        sb_q.push_back(e);
      end
      if (done_pend) done_pend = 1'b0;
      else if (draining && n == 0) begin
        draining  = 1'b0;
        done_pend = 1'b1;
      end else if (!draining && sbif.i_fence_req) draining = 1'b1;
    end
  end

  // Memory-side monitor: head must match the oldest expected store; pop on handshake.
  always @(negedge clk) begin
    if (!rst && sbif.o_mem_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mem_unexpected at %0t: got addr 0x%0h expected no request", $time, sbif.o_mem_addr);
      end else begin
        chk("mem_addr",  sbif.o_mem_addr,  sb_q[0].addr);
        chk("mem_wdata", sbif.o_mem_wdata, sb_q[0].data);
        chk("mem_be",    sbif.o_mem_be,    sb_q[0].be);
        if (sbif.i_mem_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input bit ev, input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb,
                      input bit lv, input logic [31:0] la, input bit fr, input bit mr, input bit r);
    sbif.i_enq_valid      = ev;
    sbif.i_enq_addr       = ea;
    sbif.i_enq_data       = ed;
    sbif.i_enq_be         = eb;
    sbif.i_ld_check_valid = lv;
    sbif.i_ld_check_addr  = la;
    sbif.i_fence_req      = fr;
    sbif.i_mem_ready      = mr;
    rst                   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit mr, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, mr, 0);
  endtask

  initial begin
    logic [31:0] ra, rd, rl;
    logic [3:0]  rb;
    bit          mr_bias;

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 2);

    // single store, held while memory not ready, then drained
    step(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    idle(0, 2);
    idle(1, 2);

    // five back-to-back stores into a four-entry buffer, fifth held until a slot frees
    for (int i = 0; i < 4; i++) step(1, 32'h400 + 4*i, 32'hA000 + i, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h410, 32'hA004, 4'h3, 0, 0, 0, 0, 0);
    step(1, 32'h410, 32'hA004, 4'h3, 0, 0, 0, 1, 0);
    step(1, 32'h410, 32'hA004, 4'h3, 0, 0, 0, 0, 0);
    idle(1, 6);

    // load hazard by word; zero byte-enable store is dropped
    step(1, 32'h203, 32'h000000AA, 4'h8, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h204, 0, 0, 0);
    step(1, 32'h300, 32'h12345678, 4'h0, 1, 32'h300, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h300, 0, 0, 0);
    step(1, 32'h208, 32'h55, 4'h1, 1, 32'h20B, 0, 0, 0);
    idle(1, 4);

    // fence with three pending stores, then fence on an empty buffer
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 4*i, 32'hB000 + i, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h600, 32'h1, 4'hF, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 32'h600, 32'h1, 4'hF, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 3);

    // full buffer draining under a fence with stalled enqueues, reset mid-drain
    for (int i = 0; i < 4; i++) step(1, 32'h700 + 4*i, 32'hC000 + i, 4'hF, 0, 0, 0, 0, 0);
    step(1, 32'h800, 32'h2, 4'hF, 0, 0, 1, 0, 0);
    step(1, 32'h800, 32'h2, 4'hF, 0, 0, 0, 1, 0);
    step(1, 32'h800, 32'h2, 4'hF, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 4);

    // randomized traffic over a small address window so hazards are frequent
    mr_bias = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mr_bias = ~mr_bias;
      ra = 32'h200 + $urandom_range(0, 31);
      rd = $urandom;
      rl = 32'h200 + $urandom_range(0, 31);
      rb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 2) != 0, ra, rd, rb, $urandom_range(0, 1) == 1, rl,
           $urandom_range(0, 19) == 0,
           mr_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 199) == 0);
    end
    idle(1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
